// File: rtl/elevator_scan_ctrl.sv
// SCAN-order elevator controller for NUM_FLOORS floors with timed travel and door phases.
// Requests are OR-latched until served; emergency stop freezes the car but keeps requests.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | car parked, motor halted, choosing the next action
// S_MOVE_UP    | travelling towards a higher floor
// S_MOVE_DOWN  | travelling towards a lower floor
// S_DOOR       | door open at current_floor for DOOR_CYCLES cycles
// S_EMERGENCY  | car frozen until emergency_stop is released
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emergency_stop,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  motor_stop,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending_req,
    output logic                  direction
);

    localparam int TC_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DC_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TC_W-1:0]    TRAVEL_LAST = TC_W'(TRAVEL_CYCLES - 1);
    localparam logic [DC_W-1:0]    DOOR_LAST   = DC_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR,
        S_EMERGENCY
    } state_t;

    state_t                  state, state_nxt;
    logic [FLOOR_W-1:0]      floor_nxt;
    logic                    dir_nxt;
    logic [TC_W-1:0]         travel_cnt, travel_nxt;
    logic [DC_W-1:0]         door_cnt, door_nxt;
    logic [NUM_FLOORS-1:0]   pending_nxt;

    logic [FLOOR_W-1:0]      floor_up, floor_dn;
    logic                    above_cur, below_cur, above_up, below_dn;
    logic                    at_top, at_bottom;

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0] floor);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (i > int'(floor))) any_above = 1'b1;
        end
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] req,
                                       input logic [FLOOR_W-1:0] floor);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (req[i] && (i < int'(floor))) any_below = 1'b1;
        end
    endfunction

    // Neighbour floors wrap at the ends; at_top/at_bottom keep them from being used there.
    assign floor_up  = current_floor + FLOOR_W'(1);
    assign floor_dn  = current_floor - FLOOR_W'(1);
    assign at_top    = (current_floor == TOP_FLOOR);
    assign at_bottom = (current_floor == '0);
    assign above_cur = any_above(pending_req, current_floor);
    assign below_cur = any_below(pending_req, current_floor);
    assign above_up  = any_above(pending_req, floor_up);
    assign below_dn  = any_below(pending_req, floor_dn);

    always_comb begin
        state_nxt  = state;
        floor_nxt  = current_floor;
        dir_nxt    = direction;
        travel_nxt = travel_cnt;
        door_nxt   = door_cnt;

        if (emergency_stop) begin
            state_nxt  = S_EMERGENCY;
            travel_nxt = '0;
            door_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pending_req[current_floor]) begin
                        state_nxt = S_DOOR;
                    end else if (above_cur && (direction || !below_cur)) begin
                        state_nxt = S_MOVE_UP;
                        dir_nxt   = 1'b1;
                    end else if (below_cur) begin
                        state_nxt = S_MOVE_DOWN;
                        dir_nxt   = 1'b0;
                    end
                end
                S_MOVE_UP: begin
                    if (travel_cnt == TRAVEL_LAST) begin
                        travel_nxt = '0;
                        if (at_top) begin
                            state_nxt = S_IDLE;
                        end else begin
                            floor_nxt = floor_up;
                            if (pending_req[floor_up]) state_nxt = S_DOOR;
                            else if (!above_up)        state_nxt = S_IDLE;
                        end
                    end else begin
                        travel_nxt = travel_cnt + TC_W'(1);
                    end
                end
                S_MOVE_DOWN: begin
                    if (travel_cnt == TRAVEL_LAST) begin
                        travel_nxt = '0;
                        if (at_bottom) begin
                            state_nxt = S_IDLE;
                        end else begin
                            floor_nxt = floor_dn;
                            if (pending_req[floor_dn]) state_nxt = S_DOOR;
                            else if (!below_dn)        state_nxt = S_IDLE;
                        end
                    end else begin
                        travel_nxt = travel_cnt + TC_W'(1);
                    end
                end
                S_DOOR: begin
                    if (door_cnt == DOOR_LAST) begin
                        door_nxt  = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        door_nxt = door_cnt + DC_W'(1);
                    end
                end
                S_EMERGENCY: state_nxt = S_IDLE;
                default:     state_nxt = S_IDLE;
            endcase
        end

        // The floor being served swallows its own request while the door is (about to be) open.
        pending_nxt = pending_req | floor_req;
        if (state == S_DOOR)     pending_nxt[current_floor] = 1'b0;
        if (state_nxt == S_DOOR) pending_nxt[floor_nxt]     = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            current_floor <= '0;
            pending_req   <= '0;
            direction     <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else begin
            state         <= state_nxt;
            current_floor <= floor_nxt;
            pending_req   <= pending_nxt;
            direction     <= dir_nxt;
            travel_cnt    <= travel_nxt;
            door_cnt      <= door_nxt;
        end
    end

    always_comb begin
        move_up    = (state == S_MOVE_UP);
        move_down  = (state == S_MOVE_DOWN);
        motor_stop = !((state == S_MOVE_UP) || (state == S_MOVE_DOWN));
        door_open  = (state == S_DOOR);
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios on an 8-floor car plus random traffic on
// 8-floor and 2-floor cars, both compared every cycle against a behavioural floor/timer model.
module tb_elevator_scan_ctrl;

    localparam int TRAV = 4;
    localparam int DOOR = 3;
    localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3, M_EMG = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req0;
    logic       emg0;
    logic       mu0, md0, ms0, do0, dir0;
    logic [2:0] fl0;
    logic [7:0] pend0;
    logic [1:0] req1;
    logic       emg1;
    logic       mu1, md1, ms1, do1, dir1;
    logic [0:0] fl1;
    logic [1:0] pend1;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(.NUM_FLOORS(8), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR)) u_dut8 (
        .clk(clk), .reset(reset), .floor_req(req0), .emergency_stop(emg0),
        .move_up(mu0), .move_down(md0), .motor_stop(ms0), .door_open(do0),
        .current_floor(fl0), .pending_req(pend0), .direction(dir0));

    elevator_scan_ctrl #(.NUM_FLOORS(2), .TRAVEL_CYCLES(TRAV), .DOOR_CYCLES(DOOR)) u_dut2 (
        .clk(clk), .reset(reset), .floor_req(req1), .emergency_stop(emg1),
        .move_up(mu1), .move_down(md1), .motor_stop(ms1), .door_open(do1),
        .current_floor(fl1), .pending_req(pend1), .direction(dir1));

    int n_vec = 0;
    int n_err = 0;
    bit mon_en = 0;
    bit lat_en = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position, activity and remaining-time countdown per car.
    int       nf[2] = '{8, 2};
    int       m_mode[2];
    int       m_floor[2];
    int       m_left[2];
    bit       m_dir[2];
    bit [7:0] m_pend[2];
    int       age[2][8];

    function automatic bit req_beyond(input int k, input int fl, input bit up);
        req_beyond = 0;
        for (int i = 0; i < nf[k]; i++)
            if (m_pend[k][i] && (up ? (i > fl) : (i < fl))) req_beyond = 1;
    endfunction

    task automatic model_step(input int k, input bit rst, input bit [7:0] req, input bit emg);
        bit [7:0] np;
        bit       was_door;
        if (rst) begin
            m_mode[k] = M_IDLE; m_floor[k] = 0; m_left[k] = 0; m_dir[k] = 1; m_pend[k] = '0;
            return;
        end
        np       = m_pend[k] | req;
        was_door = (m_mode[k] == M_DOOR);
        if (emg) begin
            m_mode[k] = M_EMG;
        end else begin
            case (m_mode[k])
                M_IDLE: begin
                    if (m_pend[k][m_floor[k]]) begin
                        m_mode[k] = M_DOOR; m_left[k] = DOOR;
                    end else if (req_beyond(k, m_floor[k], 1) &&
                                 (m_dir[k] || !req_beyond(k, m_floor[k], 0))) begin
                        m_mode[k] = M_UP; m_dir[k] = 1; m_left[k] = TRAV;
                    end else if (req_beyond(k, m_floor[k], 0)) begin
                        m_mode[k] = M_DN; m_dir[k] = 0; m_left[k] = TRAV;
                    end
                end
                M_UP, M_DN: begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        bit up;
                        up = (m_mode[k] == M_UP);
                        if ((up && m_floor[k] == nf[k] - 1) || (!up && m_floor[k] == 0)) begin
                            m_mode[k] = M_IDLE;
                        end else begin
                            m_floor[k] += up ? 1 : -1;
                            if (m_pend[k][m_floor[k]]) begin
                                m_mode[k] = M_DOOR; m_left[k] = DOOR;
                            end else if (req_beyond(k, m_floor[k], up)) begin
                                m_left[k] = TRAV;
                            end else begin
                                m_mode[k] = M_IDLE;
                            end
                        end
                    end
                end
                M_DOOR: begin
                    m_left[k]--;
                    if (m_left[k] == 0) m_mode[k] = M_IDLE;
                end
                default: m_mode[k] = M_IDLE;
            endcase
        end
        if (was_door || m_mode[k] == M_DOOR) np[m_floor[k]] = 0;
        m_pend[k] = np;
    endtask

    function automatic logic [4:0] exp_outs(input int k);
        exp_outs = {m_mode[k] == M_UP, m_mode[k] == M_DN,
                    !(m_mode[k] == M_UP || m_mode[k] == M_DN), m_mode[k] == M_DOOR, m_dir[k]};
    endfunction

    task automatic lat_track(input int k, input bit [7:0] p);
        for (int i = 0; i < nf[k]; i++) begin
            if (p[i]) begin
                age[k][i]++;
            end else if (age[k][i] > 0) begin
                if (lat_en)
                    check_val(k == 0 ? "k0_latency" : "k1_latency",
                              age[k][i] <= 2 * nf[k] * (TRAV + DOOR), 1);
                age[k][i] = 0;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, reset, req0, emg0);
        model_step(1, reset, {6'b0, req1}, emg1);
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check_val("k0_outs", {mu0, md0, ms0, do0, dir0}, exp_outs(0));
            check_val("k0_floor", fl0, m_floor[0]);
            check_val("k0_pend", pend0, m_pend[0]);
            check_val("k0_onehot", $countones({mu0, md0, ms0}), 1);
            check_val("k1_outs", {mu1, md1, ms1, do1, dir1}, exp_outs(1));
            check_val("k1_floor", fl1, m_floor[1]);
            check_val("k1_pend", pend1, m_pend[1]);
            check_val("k1_onehot", $countones({mu1, md1, ms1}), 1);
            lat_track(0, pend0);
            lat_track(1, {6'b0, pend1});
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic pulse_req(input logic [7:0] r);
        req0 = r; tick(); req0 = '0;
    endtask

    task automatic random_traffic(input int cycles, input bit with_emg);
        int emg_left = 0;
        for (int c = 0; c < cycles; c++) begin
            case ($urandom_range(9))
                0, 1:    req0 = 8'(1 << $urandom_range(7));
                2:       req0 = 8'($urandom & $urandom);
                default: req0 = '0;
            endcase
            req1 = ($urandom_range(4) == 0) ? 2'($urandom_range(3)) : 2'b00;
            if (with_emg && emg_left == 0 && $urandom_range(59) == 0) emg_left = $urandom_range(8, 1);
            emg0 = (emg_left > 0);
            emg1 = emg0;
            if (emg_left > 0) emg_left--;
            tick();
        end
        req0 = '0; req1 = '0; emg0 = 0; emg1 = 0;
    endtask

    initial begin
        int n;
        reset = 1; req0 = '0; req1 = '0; emg0 = 0; emg1 = 0;
        tick();
        mon_en = 1;
        tick();
        reset = 0;
        check_val("rst_outs", {mu0, md0, ms0, do0, dir0}, 5'b00101);
        check_val("rst_floor", fl0, 0);
        check_val("rst_pend", pend0, 0);

        // Floor 0 -> 5: one decision cycle, 20 travel cycles, 3 door cycles.
        pulse_req(8'h20);
        check_val("t1_latched", pend0, 8'h20);
        check_val("t1_not_moving_yet", mu0, 0);
        tick();
        n = 0;
        while (mu0 && n < 100) begin n++; tick(); end
        check_val("t1_move_cycles", n, 20);
        check_val("t1_floor", fl0, 5);
        n = 0;
        while (do0 && n < 20) begin n++; tick(); end
        check_val("t1_door_cycles", n, 3);
        check_val("t1_idle", {ms0, do0, pend0}, {1'b1, 1'b0, 8'h00});

        // SCAN: finish upward sweep to 6 before turning back for 1.
        pulse_reset();
        pulse_req(8'h40);
        n = 0;
        while (fl0 != 3 && n < 100) begin n++; tick(); end
        check_val("t2_at3_moving_up", {fl0, mu0}, {3'd3, 1'b1});
        pulse_req(8'h42);
        n = 0;
        while (!do0 && n < 100) begin n++; tick(); end
        check_val("t2_first_stop", {fl0, dir0}, {3'd6, 1'b1});
        n = 0;
        while (!md0 && n < 100) begin n++; tick(); end
        check_val("t2_dir_flip", {md0, dir0}, 2'b10);
        n = 0;
        while (!do0 && n < 100) begin n++; tick(); end
        check_val("t2_second_stop", fl0, 1);

        // Emergency mid-transit discards partial travel.
        pulse_reset();
        pulse_req(8'h80);
        n = 0;
        while (!mu0 && n < 20) begin n++; tick(); end
        check_val("t3_moving", mu0, 1);
        tick(2);
        emg0 = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t3_frozen", {fl0, ms0, pend0}, {3'd0, 1'b1, 8'h80});
        end
        emg0 = 0;
        tick();
        check_val("t3_idle_after", {mu0, ms0}, 2'b01);
        tick();
        n = 0;
        while (mu0 && fl0 == 0 && n < 20) begin n++; tick(); end
        check_val("t3_full_transit", n, 4);
        check_val("t3_next_floor", fl0, 1);

        // Request at the car's own floor; a repeat during DOOR is absorbed.
        pulse_reset();
        pulse_req(8'h01);
        check_val("t4_latched", {pend0, do0}, {8'h01, 1'b0});
        tick();
        check_val("t4_door", {do0, pend0}, {1'b1, 8'h00});
        pulse_req(8'h01);
        check_val("t4_absorbed", pend0, 8'h00);
        n = 0;
        while (do0 && n < 20) begin n++; tick(); end
        check_val("t4_door_rest", n, 2);
        for (int i = 0; i < 5; i++) begin
            check_val("t4_no_redoor", {do0, pend0}, 9'h000);
            tick();
        end

        // Reset in the middle of a door phase.
        pulse_reset();
        pulse_req(8'h10);
        n = 0;
        while (!do0 && n < 100) begin n++; tick(); end
        check_val("t5_door_at4", {do0, fl0}, {1'b1, 3'd4});
        pulse_req(8'h04);
        pulse_reset();
        check_val("t5_outs", {mu0, md0, ms0, do0, dir0}, 5'b00101);
        check_val("t5_floor_pend", {fl0, pend0}, {3'd0, 8'h00});

        random_traffic(600, 1);

        pulse_reset();
        tick();
        lat_en = 1;
        random_traffic(2000, 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < nf[k]; i++)
                check_val("final_age", age[k][i] <= 2 * nf[k] * (TRAV + DOOR), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
